// File: rtl/pitch_pkg.sv
// Shared types and helpers for the overlap-add pitch / time-stretch core.
package pitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_REQ,
        ST_MAC,
        ST_WR_REQ,
        ST_NEXT,
        ST_FLUSH_WR,
        ST_DONE
    } pitch_state_t;

    typedef enum logic {
        PM_TSTRETCH = 1'b0,
        PM_PSHIFT   = 1'b1
    } pitch_mode_t;

    localparam logic [3:0] SPEED_ONE = 4'd8;

    // Clamp a signed value to the range of a dw-bit two's complement number.
    function automatic logic signed [31:0] sat_to_width(input logic signed [32:0] v, input int dw);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (longint'(v) > hi)
            return hi[31:0];
        else if (longint'(v) < lo)
            return lo[31:0];
        else
            return v[31:0];
    endfunction

endpackage

// File: rtl/pitch_window_mac.sv
// One channel of the window multiply-accumulate: tail + ((sample * weight) >>> log2(HS)), saturated.
module pitch_window_mac
    import pitch_pkg::*;
#(
    parameter int DW = 16,
    parameter int LW = 8
) (
    input  logic signed [DW-1:0] sample,
    input  logic        [LW-1:0] weight,
    input  logic signed [DW-1:0] tail,
    output logic signed [DW-1:0] sum
);

    localparam int PW = DW + LW;
    typedef logic signed [PW-1:0] prod_t;

    prod_t              prod;
    logic signed [DW:0] sum_w;

    // The scaled product never exceeds |sample|, so DW+1 bits hold it exactly.
    always_comb begin
        prod  = prod_t'(sample) * prod_t'($signed({1'b0, weight}));
        sum_w = $signed({tail[DW-1], tail}) + (DW + 1)'(prod >>> (LW - 1));
        sum   = DW'(sat_to_width(33'(sum_w), DW));
    end

endmodule

// File: rtl/pitch_ola_core.sv
// Overlap-add time-stretch / pitch-shift engine streaming grains between SDRAM regions.
module pitch_ola_core
    import pitch_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CH    = 2,
    parameter int AW    = 23,
    parameter int FRAME = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          pitch_start,
    input  logic [AW-1:0] pitch_src_start,
    input  logic [AW-1:0] pitch_src_end,
    input  logic [AW-1:0] pitch_dst_start,
    input  logic          pitch_mode,
    input  logic [3:0]    pitch_speed,
    output logic          pitch_done,
    output logic          o_busy,
    output logic [AW-1:0] o_out_len,
    output logic          pitch_read,
    output logic          pitch_write,
    output logic [AW-1:0] pitch_addr,
    input  logic [31:0]   pitch_readdata,
    output logic [31:0]   pitch_writedata,
    input  logic          pitch_sdram_finished
);

    localparam int HS = FRAME / 2;
    localparam int LG = $clog2(HS);
    localparam int LW = LG + 1;
    localparam int FB = $clog2(FRAME);

    pitch_state_t  state;
    pitch_mode_t   mode_q;
    logic [3:0]    speed_q;
    logic [AW-1:0] src_start_q, src_end_q, dst_q;
    logic [AW-1:0] a_base, wptr;
    logic [AW+2:0] a_frac;
    logic [FB-1:0] i_cnt;
    logic [LG:0]   k_cnt;
    logic          fl_rd, tail_valid;
    logic [31:0]   x_q;

    logic [31:0]   tail_mem [HS];
    logic [31:0]   tail_q;
    logic [LG-1:0] ram_addr;
    logic          ram_we;

    logic [FB+3:0] span, rd_off;
    logic [AW-1:0] rd_addr;
    logic [AW+2:0] a_frac_next;
    logic          grain_ok;
    logic [LW-1:0] weight;
    logic          hi_half;
    logic [31:0]   mac_word;
    logic signed [DW-1:0] mac_out [CH];

    // Second half of the grain only builds the tail; the first half overlaps it.
    always_comb begin
        hi_half     = i_cnt[FB-1];
        span        = (mode_q == PM_PSHIFT) ? ((FB + 4)'(FRAME - 1) * (FB + 4)'(speed_q)) >> 3
                                            : (FB + 4)'(FRAME - 1);
        rd_off      = (mode_q == PM_PSHIFT) ? ((FB + 4)'(i_cnt) * (FB + 4)'(speed_q)) >> 3
                                            : (FB + 4)'(i_cnt);
        rd_addr     = a_base + AW'(rd_off);
        grain_ok    = ({1'b0, a_base} + (AW + 1)'(span)) <= {1'b0, src_end_q};
        a_frac_next = a_frac + (AW + 3)'(HS * speed_q);
        weight      = hi_half ? LW'(HS) - {1'b0, i_cnt[LG-1:0]} : {1'b0, i_cnt[LG-1:0]};
        ram_addr    = (state == ST_FLUSH_WR) ? k_cnt[LG-1:0] : i_cnt[LG-1:0];
        ram_we      = (state == ST_MAC) && hi_half;
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DW-1:0] tail_in;
        assign tail_in = (tail_valid && !hi_half) ? $signed(tail_q[c*DW +: DW]) : '0;

        pitch_window_mac #(.DW(DW), .LW(LW)) u_mac (
            .sample (x_q[c*DW +: DW]),
            .weight (weight),
            .tail   (tail_in),
            .sum    (mac_out[c])
        );
    end

    always_comb begin
        mac_word = '0;
        for (int c = 0; c < CH; c++)
            mac_word[c*DW +: DW] = mac_out[c];
    end

    // NOTE: the tail RAM has no reset; tail_valid masks whatever it holds until a grain has filled it.
    always_ff @(posedge i_clk) begin
        if (ram_we)
            tail_mem[ram_addr] <= mac_word;
        tail_q <= tail_mem[ram_addr];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            mode_q          <= PM_TSTRETCH;
            speed_q         <= SPEED_ONE;
            src_start_q     <= '0;
            src_end_q       <= '0;
            dst_q           <= '0;
            a_base          <= '0;
            a_frac          <= '0;
            wptr            <= '0;
            i_cnt           <= '0;
            k_cnt           <= '0;
            fl_rd           <= 1'b0;
            tail_valid      <= 1'b0;
            x_q             <= '0;
            pitch_done      <= 1'b0;
            o_busy          <= 1'b0;
            o_out_len       <= '0;
            pitch_read      <= 1'b0;
            pitch_write     <= 1'b0;
            pitch_addr      <= '0;
            pitch_writedata <= '0;
        end else begin
            pitch_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (pitch_start && !pitch_done) begin
                        mode_q      <= pitch_mode_t'(pitch_mode);
                        speed_q     <= (pitch_speed == 4'd0) ? SPEED_ONE : pitch_speed;
                        src_start_q <= pitch_src_start;
                        src_end_q   <= pitch_src_end;
                        dst_q       <= pitch_dst_start;
                        a_base      <= pitch_src_start;
                        a_frac      <= '0;
                        wptr        <= pitch_dst_start;
                        i_cnt       <= '0;
                        tail_valid  <= 1'b0;
                        o_busy      <= 1'b1;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (grain_ok) begin
                        pitch_read <= 1'b1;
                        pitch_addr <= rd_addr;
                        state      <= ST_RD_REQ;
                    end else if (tail_valid) begin
                        k_cnt <= '0;
                        fl_rd <= 1'b0;
                        state <= ST_FLUSH_WR;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (!pitch_read) begin
                        pitch_read <= 1'b1;
                        pitch_addr <= rd_addr;
                    end else if (pitch_sdram_finished) begin
                        pitch_read <= 1'b0;
                        x_q        <= pitch_readdata;
                        state      <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (!hi_half) begin
                        pitch_write     <= 1'b1;
                        pitch_addr      <= wptr;
                        pitch_writedata <= mac_word;
                        state           <= ST_WR_REQ;
                    end else if (&i_cnt) begin
                        state <= ST_NEXT;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                        state <= ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (pitch_sdram_finished) begin
                        pitch_write <= 1'b0;
                        wptr        <= wptr + 1'b1;
                        i_cnt       <= i_cnt + 1'b1;
                        state       <= ST_RD_REQ;
                    end
                end
                ST_NEXT: begin
                    i_cnt      <= '0;
                    tail_valid <= 1'b1;
                    if (mode_q == PM_PSHIFT) begin
                        a_base <= a_base + AW'(HS);
                    end else begin
                        a_frac <= a_frac_next;
                        a_base <= src_start_q + AW'(a_frac_next >> 3);
                    end
                    state <= ST_CHECK;
                end
                ST_FLUSH_WR: begin
                    // fl_rd marks that tail_q now holds tail[k_cnt].
                    if (pitch_write) begin
                        if (pitch_sdram_finished) begin
                            pitch_write <= 1'b0;
                            wptr        <= wptr + 1'b1;
                            k_cnt       <= k_cnt + 1'b1;
                        end
                    end else if (k_cnt == (LG + 1)'(HS)) begin
                        state <= ST_DONE;
                    end else if (!fl_rd) begin
                        fl_rd <= 1'b1;
                    end else begin
                        pitch_write     <= 1'b1;
                        pitch_addr      <= wptr;
                        pitch_writedata <= tail_q;
                        fl_rd           <= 1'b0;
                    end
                end
                ST_DONE: begin
                    pitch_done <= 1'b1;
                    o_busy     <= 1'b0;
                    o_out_len  <= wptr - dst_q;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_ola_core.sv
// Directed bench for pitch_ola_core with FRAME=8 and a behavioural SDRAM port of variable latency.
module tb_pitch_ola_core;

    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int AW    = 23;
    localparam int FRAME = 8;

    logic          i_clk;
    logic          i_rst_n;
    logic          pitch_start;
    logic [AW-1:0] pitch_src_start, pitch_src_end, pitch_dst_start;
    logic          pitch_mode;
    logic [3:0]    pitch_speed;
    logic          pitch_done, o_busy;
    logic [AW-1:0] o_out_len;
    logic          pitch_read, pitch_write;
    logic [AW-1:0] pitch_addr;
    logic [31:0]   pitch_readdata, pitch_writedata;
    logic          pitch_sdram_finished;

    pitch_ola_core #(.DW(DW), .CH(CH), .AW(AW), .FRAME(FRAME)) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .pitch_start          (pitch_start),
        .pitch_src_start      (pitch_src_start),
        .pitch_src_end        (pitch_src_end),
        .pitch_dst_start      (pitch_dst_start),
        .pitch_mode           (pitch_mode),
        .pitch_speed          (pitch_speed),
        .pitch_done           (pitch_done),
        .o_busy               (o_busy),
        .o_out_len            (o_out_len),
        .pitch_read           (pitch_read),
        .pitch_write          (pitch_write),
        .pitch_addr           (pitch_addr),
        .pitch_readdata       (pitch_readdata),
        .pitch_writedata      (pitch_writedata),
        .pitch_sdram_finished (pitch_sdram_finished)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed per-channel outputs for a uniform source (ch0 = 1000, ch1 = -1001).
    int first_c0[4]  = '{0, 250, 500, 750};
    int first_c1[4]  = '{0, -251, -501, -751};
    int steady_c0[4] = '{1000, 1000, 1000, 1000};
    int steady_c1[4] = '{-1001, -1002, -1002, -1002};
    int flush_c0[4]  = '{1000, 750, 500, 250};
    int flush_c1[4]  = '{-1001, -751, -501, -251};

    function automatic logic [31:0] pk(input int c0, input int c1);
        logic [15:0] lo, hi;
        lo = 16'(c0);
        hi = 16'(c1);
        return {hi, lo};
    endfunction

    function automatic logic [31:0] exp_word(input int grains, input int k);
        if (k < 4)
            return pk(first_c0[k], first_c1[k]);
        else if (k < 4 * grains)
            return pk(steady_c0[k % 4], steady_c1[k % 4]);
        else
            return pk(flush_c0[k - 4 * grains], flush_c1[k - 4 * grains]);
    endfunction

    // SDRAM model: responds on the falling edge after a random 1..lat_max cycle wait.
    logic [31:0]   sdram [256];
    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];
    int            lat_max = 1;
    int            wait_cnt, cur_lat;
    logic          req_seen;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    int            viol_rw   = 0;
    int            viol_hold = 0;

    initial begin
        pitch_sdram_finished = 1'b0;
        pitch_readdata       = 32'hdead_beef;
        req_seen             = 1'b0;
    end

    always @(negedge i_clk) begin
        if (!i_rst_n || !(pitch_read || pitch_write)) begin
            pitch_sdram_finished = 1'b0;
            pitch_readdata       = 32'hdead_beef;
            req_seen             = 1'b0;
        end else if (pitch_sdram_finished) begin
            pitch_sdram_finished = 1'b0;
            pitch_readdata       = 32'hdead_beef;
            req_seen             = 1'b0;
        end else begin
            if (pitch_read && pitch_write)
                viol_rw++;
            if (!req_seen) begin
                req_seen = 1'b1;
                req_addr = pitch_addr;
                req_data = pitch_writedata;
                cur_lat  = $urandom_range(1, lat_max);
                wait_cnt = 0;
            end else if (pitch_addr != req_addr || (pitch_write && pitch_writedata != req_data)) begin
                viol_hold++;
            end
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
                pitch_sdram_finished = 1'b1;
                if (pitch_read) begin
                    pitch_readdata = sdram[req_addr[7:0]];
                    rd_addr_q.push_back(req_addr);
                end else begin
                    wr_addr_q.push_back(req_addr);
                    wr_data_q.push_back(req_data);
                end
            end
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic launch(input int s, input int e, input int d, input logic m, input logic [3:0] sp);
        clear_logs();
        @(negedge i_clk);
        pitch_src_start = AW'(s);
        pitch_src_end   = AW'(e);
        pitch_dst_start = AW'(d);
        pitch_mode      = m;
        pitch_speed     = sp;
        pitch_start     = 1'b1;
        @(negedge i_clk);
        pitch_start = 1'b0;
    endtask

    task automatic run_job(input int s, input int e, input int d, input logic m, input logic [3:0] sp,
                           output int done_cyc, output int first_rd, output logic busy_at_done);
        int cyc;
        launch(s, e, d, m, sp);
        cyc      = 1;
        first_rd = -1;
        while (!pitch_done && cyc < 20000) begin
            if (pitch_read && first_rd < 0)
                first_rd = cyc;
            @(negedge i_clk);
            cyc++;
        end
        if (!pitch_done)
            check("done_timeout", 64'(cyc), 64'(0));
        done_cyc     = cyc;
        busy_at_done = o_busy;
    endtask

    task automatic check_stream(input string tag, input int grains, input int dst);
        int n;
        n = 4 * grains + 4;
        check({tag, "_wr_count"}, 64'(wr_data_q.size()), 64'(n));
        for (int k = 0; k < n && k < wr_data_q.size(); k++) begin
            check({tag, "_wr_addr"}, 64'(wr_addr_q[k]), 64'(dst + k));
            check({tag, "_wr_data"}, 64'(wr_data_q[k]), 64'(exp_word(grains, k)));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({pitch_done, o_busy, pitch_read, pitch_write}), 64'(0));
        check({tag, "_len"},  64'(o_out_len), 64'(0));
        check({tag, "_addr"}, 64'(pitch_addr), 64'(0));
        check({tag, "_wdata"}, 64'(pitch_writedata), 64'(0));
    endtask

    int   dc, fr;
    logic bz;
    int   ps_rd[8] = '{0, 1, 3, 4, 6, 7, 9, 10};

    initial begin
        for (int a = 0; a < 256; a++)
            sdram[a] = pk(1000, -1001);
        i_rst_n         = 1'b0;
        pitch_start     = 1'b0;
        pitch_src_start = '0;
        pitch_src_end   = '0;
        pitch_dst_start = '0;
        pitch_mode      = 1'b0;
        pitch_speed     = 4'd0;
        repeat (3) @(negedge i_clk);
        check_outputs_zero("reset");
        i_rst_n = 1'b1;

        // Time-stretch at unity speed: four grains.
        run_job(0, 19, 100, 1'b0, 4'd8, dc, fr, bz);
        check("s1_first_read_cycle", 64'(fr), 64'(2));
        check("s1_busy_at_done", 64'(bz), 64'(0));
        check("s1_out_len", 64'(o_out_len), 64'(20));
        check("s1_read_count", 64'(rd_addr_q.size()), 64'(32));
        check_stream("s1", 4, 100);

        // Time-stretch at half speed: seven grains stepping by two.
        run_job(0, 19, 100, 1'b0, 4'd4, dc, fr, bz);
        check("s2_out_len", 64'(o_out_len), 64'(32));
        check("s2_grain7_base", 64'(rd_addr_q.size() >= 49 ? rd_addr_q[48] : '1), 64'(12));
        check_stream("s2", 7, 100);

        // Pitch shift at 1.5x: resampled reads, three grains.
        run_job(0, 19, 200, 1'b1, 4'd12, dc, fr, bz);
        check("s3_out_len", 64'(o_out_len), 64'(16));
        check("s3_read_count", 64'(rd_addr_q.size()), 64'(24));
        for (int k = 0; k < 8 && k < rd_addr_q.size(); k++)
            check("s3_rd_addr", 64'(rd_addr_q[k]), 64'(ps_rd[k]));
        check("s3_grain2_base", 64'(rd_addr_q.size() >= 9 ? rd_addr_q[8] : '1), 64'(4));
        check_stream("s3", 3, 200);

        // Random completion latency: handshake rules and identical results.
        lat_max   = 5;
        viol_rw   = 0;
        viol_hold = 0;
        run_job(0, 19, 100, 1'b0, 4'd8, dc, fr, bz);
        check("s4_rw_exclusive", 64'(viol_rw), 64'(0));
        check("s4_req_stable", 64'(viol_hold), 64'(0));
        check("s4_out_len", 64'(o_out_len), 64'(20));
        check_stream("s4", 4, 100);
        lat_max = 1;

        // Speed 0 behaves as unity; a region too short for one grain does nothing.
        run_job(0, 19, 100, 1'b0, 4'd0, dc, fr, bz);
        check("s5_speed0_len", 64'(o_out_len), 64'(20));
        check_stream("s5", 4, 100);
        run_job(10, 16, 300, 1'b0, 4'd8, dc, fr, bz);
        check("s5_empty_done_cycle", 64'(dc), 64'(3));
        check("s5_empty_accesses", 64'(rd_addr_q.size() + wr_data_q.size()), 64'(0));
        check("s5_empty_len", 64'(o_out_len), 64'(0));

        // Reset mid-grain, then a clean restart.
        run_job(0, 19, 100, 1'b0, 4'd8, dc, fr, bz);
        launch(0, 19, 100, 1'b0, 4'd8);
        for (int c = 0; c < 2000 && wr_data_q.size() < 6; c++)
            @(negedge i_clk);
        check("s6_reached_mid_run", 64'(wr_data_q.size() >= 6), 64'(1));
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_outputs_zero("s6_reset");
        i_rst_n = 1'b1;
        run_job(0, 19, 100, 1'b0, 4'd8, dc, fr, bz);
        check("s6_out_len", 64'(o_out_len), 64'(20));
        check_stream("s6", 4, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
